// File: rtl/dbg_meas_ctrl.sv
// dbg_meas_ctrl: host-programmed edge-count measurement controller.
// Counts clock cycles spanning N rising edges of an asynchronous input,
// driving clear/gate pulses to an external debug counter.
// Optional feature: define DBG_MEAS_TIMEOUT_EN to enable the ARM/MEAS timeout.
`timescale 1ns/1ps
module dbg_meas_ctrl #(
  parameter int WE_WIDTH = 8,
  parameter int RE_WIDTH = 8,
  parameter int C_CYC_WH = 16,
  parameter int TO_WH    = 12
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [WE_WIDTH-1:0] iWE_BIT,
  input  logic [RE_WIDTH-1:0] iRE_BIT,
  input  logic [7:0]          iDATA,
  output logic [7:0]          oRD,
  input  logic                iSIG,
  output logic                oCLR,
  output logic                oGATE,
  output logic                oBUSY,
  output logic                oDONE
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_ARM, S_MEAS, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic                rise_q, rise_d;
  logic [7:0]          n_q, n_d;
  logic [C_CYC_WH-1:0] cyc_q, cyc_d;
  logic [7:0]          ecnt_q, ecnt_d;
  logic                err_q, err_d, ovf_q, ovf_d;
  logic                to_hit, to_flag;
  logic                ctrl_wr, n_wr, start, abort, ack;
  logic [15:0]         cyc_rd;
  logic [7:0]          rd_data;

  // Register strobes are strict one-hot; anything else is not a write.
  assign ctrl_wr = (iWE_BIT == WE_WIDTH'(1));
  assign n_wr    = (iWE_BIT == WE_WIDTH'(2));
  assign start   = ctrl_wr & iDATA[0];
  assign abort   = ctrl_wr & iDATA[1];
  assign ack     = ctrl_wr & iDATA[2];

  // Two-flop synchronizer, history flop and registered single-cycle rise.
  always_comb begin
    sync1_d = iSIG;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    rise_d  = sync2_q & ~sync3_q;
  end

  // State and result registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      rise_q  <= 1'b0;
      n_q     <= 8'h01;
      cyc_q   <= '0;
      ecnt_q  <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
      rise_q  <= rise_d;
      n_q     <= n_d;
      cyc_q   <= cyc_d;
      ecnt_q  <= ecnt_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef DBG_MEAS_TIMEOUT_EN
  logic [TO_WH-1:0] to_cnt_q, to_cnt_d;
  logic             to_flag_q, to_flag_d;

  // Timeout counter: restarts on ARM entry and on every rise; expiry ends the run.
  always_comb begin
    to_cnt_d  = to_cnt_q;
    to_flag_d = to_flag_q;
    to_hit    = 1'b0;
    if (state_q == S_CLR || rise_q) begin
      to_cnt_d = '0;
    end else if (state_q == S_ARM || state_q == S_MEAS) begin
      to_cnt_d = to_cnt_q + TO_WH'(1);
      to_hit   = (to_cnt_d == {TO_WH{1'b1}});
    end
    if (state_q == S_CLR)     to_flag_d = 1'b0;
    else if (to_hit && !abort) to_flag_d = 1'b1;
  end

  // Timeout registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      to_flag_q <= to_flag_d;
    end
  end

  assign to_flag = to_flag_q;
`else
  assign to_hit  = 1'b0;
  assign to_flag = 1'b0;
`endif

  // FSM next state and result updates; ABORT pre-empts everything else.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cyc_d   = cyc_q;
    ecnt_d  = ecnt_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    if (n_wr && state_q == S_IDLE) n_d = iDATA;
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          if (n_q != 8'h00) begin
            state_d = S_CLR;
            err_d   = 1'b0;
          end else begin
            err_d   = 1'b1;
          end
        end
        S_CLR: begin
          state_d = S_ARM;
          cyc_d   = '0;
          ecnt_d  = '0;
          ovf_d   = 1'b0;
        end
        S_ARM: begin
          // The arming edge only opens the gate; it is not counted.
          if (rise_q)      state_d = S_MEAS;
          else if (to_hit) state_d = S_DONE;
        end
        S_MEAS: begin
          if (cyc_q == {C_CYC_WH{1'b1}}) ovf_d = 1'b1;
          else                           cyc_d = cyc_q + C_CYC_WH'(1);
          if (rise_q) begin
            ecnt_d = ecnt_q + 8'd1;
            if (ecnt_d == n_q) state_d = S_DONE;
          end else if (to_hit) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (start) begin
            state_d = S_CLR;
            err_d   = 1'b0;
          end else if (ack) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign oCLR  = (state_q == S_CLR);
  assign oGATE = (state_q == S_MEAS);
  assign oBUSY = (state_q == S_CLR) || (state_q == S_ARM) || (state_q == S_MEAS);
  assign oDONE = (state_q == S_DONE);

  assign cyc_rd = 16'(cyc_q);

  // Host read mux: exactly one select bit picks a register, anything else reads zero.
  always_comb begin
    rd_data = 8'h00;
    if      (iRE_BIT == RE_WIDTH'(1))  rd_data = {3'b000, to_flag, ovf_q, err_q, oDONE, oBUSY};
    else if (iRE_BIT == RE_WIDTH'(2))  rd_data = n_q;
    else if (iRE_BIT == RE_WIDTH'(4))  rd_data = cyc_rd[7:0];
    else if (iRE_BIT == RE_WIDTH'(8))  rd_data = cyc_rd[15:8];
    else if (iRE_BIT == RE_WIDTH'(16)) rd_data = ecnt_q;
  end

  assign oRD = rd_data;

endmodule

// File: doc/dbg_meas_ctrl.md
DBG_MEAS_CTRL -- requirements
Module: dbg_meas_ctrl

Interface
REQ-001 SHALL have parameter WE_WIDTH, default 8, meaning write-enable bit-vector width from HOST_IF.
REQ-002 SHALL have parameter RE_WIDTH, default 8, meaning read-enable bit-vector width from HOST_IF.
REQ-003 SHALL have parameter C_CYC_WH, default 16, meaning measured-cycle counter width.
REQ-004 SHALL have parameter TO_WH, default 12, meaning timeout counter width.
REQ-005 SHALL have port CLK  input  1  single system clock; all logic on rising edge.
REQ-006 SHALL have port RST_N  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port iWE_BIT  input  WE_WIDTH  one-hot register write strobes.
REQ-008 SHALL have port iRE_BIT  input  RE_WIDTH  one-hot register read selects.
REQ-009 SHALL have port iDATA  input  8  host write data.
REQ-010 SHALL have port oRD  output  8  host read data, combinational from iRE_BIT.
REQ-011 SHALL have port iSIG  input  1  asynchronous signal under measurement.
REQ-012 SHALL have ports oCLR, oGATE, oBUSY, oDONE  output  1 each: debug-counter clear pulse, count gate, busy flag, done flag.

Function
REQ-013 iSIG SHALL pass a 2-flop synchronizer then an edge detector; "rise" asserts for one cycle, 3 CLK after iSIG is first sampled high.
REQ-014 Registers: WE_BIT[0] CTRL (iDATA[0]=START, [1]=ABORT, [2]=ACK); WE_BIT[1] N, 8-bit edge target, write ignored unless IDLE.
REQ-015 Read map: RE_BIT[0] status {3'b0,TO,OVF,ERR,DONE,BUSY}; [1] N; [2] cyc[7:0]; [3] cyc[15:8]; [4] edge_cnt; zero bits, multiple bits or other bits -> 8'h00.
REQ-016 FSM states SHALL be IDLE, CLR, ARM, MEAS, DONE.
REQ-017 IDLE: START with N!=0 -> CLR and ERR cleared; START with N==0 -> stay IDLE, ERR=1.
REQ-018 CLR: oCLR=1 for exactly one cycle; cyc, edge_cnt, OVF, TO cleared; -> ARM.
REQ-019 ARM: wait for rise -> MEAS (arming edge not counted).
REQ-020 MEAS: oGATE=1; cyc increments every MEAS cycle incl. terminating cycle, saturating at all-ones with OVF=1; each rise increments edge_cnt; rise making edge_cnt==N -> DONE.
REQ-021 DONE: oDONE=1, results frozen; START -> CLR; ACK -> IDLE with DONE cleared, results retained.
REQ-022 ABORT in any non-IDLE state -> IDLE next cycle, oGATE=0, results retained; ABORT wins over simultaneous START/ACK.
REQ-023 oBUSY=1 in CLR, ARM, MEAS; status DONE bit mirrors oDONE.

Reset
REQ-024 On RST_N low at a CLK edge: FSM=IDLE, all outputs 0, cyc=0, edge_cnt=0, status bits 0, N=8'h01; applies mid-operation too.

Configuration
REQ-025 Macro DBG_MEAS_TIMEOUT_EN defined: TO_WH-bit counter cleared on entering ARM and on every rise; reaching 2^TO_WH-1 in ARM or MEAS -> DONE with TO=1.
REQ-026 Macro undefined: no timeout logic; ARM/MEAS wait indefinitely; TO reads 0.

Verification
REQ-027 N=3, iSIG period 10 (5H/5L), START -> one oCLR cycle, DONE with cyc=30, edge_cnt=3, OVF=0.
REQ-028 N=0, START -> no oCLR, oBUSY stays 0, status=8'h04.
REQ-029 START+ABORT in same cycle during MEAS -> IDLE next cycle, oGATE=0, oBUSY=0.
REQ-030 N=1, iSIG period 70000 -> cyc=16'hFFFF, OVF=1, status=8'h0A.
REQ-031 iSIG held low, macro on, TO_WH=12 -> DONE 4095 cycles after ARM entry with TO=1; macro off -> oBUSY=1 after 10000 cycles.
REQ-032 RST_N low one cycle mid-MEAS -> all outputs 0 and N=8'h01 after that edge.
